// File: rtl/attack_eval.sv
`default_nettype none
// ============================================================================
// Module   : attack_eval
// Purpose  : Captures the two attack maps on a done edge. Scans them one rank
//            per cycle and produces a saturated White-minus-Black score.
// Revision : 1.0 - initial release
// ============================================================================
module attack_eval #(
    parameter int SCORE_WIDTH   = 16,
    parameter int CENTER_WEIGHT = 1,
    parameter int CHECK_PENALTY = 50
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [63:0]                   white_is_attacking,
    input  logic [63:0]                   black_is_attacking,
    input  logic                          white_in_check,
    input  logic                          black_in_check,
    input  logic                          is_attacking_done,
    output logic                          eval_valid,
    output logic signed [SCORE_WIDTH-1:0] score,
    output logic [6:0]                    white_count,
    output logic [6:0]                    black_count,
    output logic                          busy,
    output logic                          overrun
);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_SCAN   = 2'd1;
    localparam logic [1:0] S_FINISH = 2'd2;

    localparam logic signed [31:0] c_center_weight = CENTER_WEIGHT;
    localparam logic signed [31:0] c_check_penalty = CHECK_PENALTY;
    localparam logic signed [32:0] c_sat_max = (33'sd1 <<< (SCORE_WIDTH - 1)) - 33'sd1;
    localparam logic signed [32:0] c_sat_min = -(33'sd1 <<< (SCORE_WIDTH - 1));

    function automatic logic [3:0] popcount8(input logic [7:0] b);
        logic [3:0] n;
        n = 4'd0;
        for (int i = 0; i < 8; i++) begin
            n = n + {3'd0, b[i]};
        end
        return n;
    endfunction

    logic [1:0]                   r_state;
    logic [1:0]                   w_next_state;
    logic                         r_done_q;
    logic                         w_start;
    logic [63:0]                  r_white_map;
    logic [63:0]                  r_black_map;
    logic                         r_white_chk;
    logic                         r_black_chk;
    logic [2:0]                   r_rank;
    logic [6:0]                   r_white_acc;
    logic [6:0]                   r_black_acc;
    logic [2:0]                   r_white_ctr;
    logic [2:0]                   r_black_ctr;
    logic                         r_eval_valid;
    logic signed [SCORE_WIDTH-1:0] r_score;
    logic [6:0]                   r_white_count;
    logic [6:0]                   r_black_count;
    logic                         r_overrun;

    logic [7:0]                   w_white_byte;
    logic [7:0]                   w_black_byte;
    logic                         w_center_rank;
    logic [1:0]                   w_white_center_add;
    logic [1:0]                   w_black_center_add;
    logic signed [31:0]           w_white_tot;
    logic signed [31:0]           w_black_tot;
    logic signed [31:0]           w_raw;
    logic signed [32:0]           w_raw_ext;
    logic signed [SCORE_WIDTH-1:0] w_score_sat;

    assign w_start = is_attacking_done & ~r_done_q;

    assign w_white_byte  = r_white_map[{r_rank, 3'b000} +: 8];
    assign w_black_byte  = r_black_map[{r_rank, 3'b000} +: 8];
    // Central squares d4/e4/d5/e5 sit on files 3 and 4 of ranks 3 and 4 only.
    assign w_center_rank      = (r_rank == 3'd3) || (r_rank == 3'd4);
    assign w_white_center_add = w_center_rank ? ({1'b0, w_white_byte[3]} + {1'b0, w_white_byte[4]}) : 2'd0;
    assign w_black_center_add = w_center_rank ? ({1'b0, w_black_byte[3]} + {1'b0, w_black_byte[4]}) : 2'd0;

    assign w_white_tot = $signed({25'd0, r_white_acc}) + c_center_weight * $signed({29'd0, r_white_ctr});
    assign w_black_tot = $signed({25'd0, r_black_acc}) + c_center_weight * $signed({29'd0, r_black_ctr});
    assign w_raw       = w_white_tot - w_black_tot
                       - (r_white_chk ? c_check_penalty : 32'sd0)
                       + (r_black_chk ? c_check_penalty : 32'sd0);
    assign w_raw_ext   = {w_raw[31], w_raw};

    always_comb begin
        w_score_sat = w_raw[SCORE_WIDTH-1:0];
        if (w_raw_ext > c_sat_max) begin
            w_score_sat = c_sat_max[SCORE_WIDTH-1:0];
        end else if (w_raw_ext < c_sat_min) begin
            w_score_sat = c_sat_min[SCORE_WIDTH-1:0];
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE:   if (w_start) w_next_state = S_SCAN;
            S_SCAN:   if (r_rank == 3'd7) w_next_state = S_FINISH;
            S_FINISH: w_next_state = S_IDLE;
            default:  w_next_state = S_IDLE;
        endcase
    end

    always_comb begin
        busy = (r_state != S_IDLE);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_done_q      <= 1'b0;
            r_white_map   <= 64'd0;
            r_black_map   <= 64'd0;
            r_white_chk   <= 1'b0;
            r_black_chk   <= 1'b0;
            r_rank        <= 3'd0;
            r_white_acc   <= 7'd0;
            r_black_acc   <= 7'd0;
            r_white_ctr   <= 3'd0;
            r_black_ctr   <= 3'd0;
            r_eval_valid  <= 1'b0;
            r_score       <= '0;
            r_white_count <= 7'd0;
            r_black_count <= 7'd0;
            r_overrun     <= 1'b0;
        end else begin
            r_done_q     <= is_attacking_done;
            r_eval_valid <= 1'b0;
            // Any start edge seen outside IDLE (FINISH included) is lost.
            if (w_start && (r_state != S_IDLE)) begin
                r_overrun <= 1'b1;
            end
            case (r_state)
                S_IDLE: begin
                    if (w_start) begin
                        r_white_map <= white_is_attacking;
                        r_black_map <= black_is_attacking;
                        r_white_chk <= white_in_check;
                        r_black_chk <= black_in_check;
                        r_rank      <= 3'd0;
                        r_white_acc <= 7'd0;
                        r_black_acc <= 7'd0;
                        r_white_ctr <= 3'd0;
                        r_black_ctr <= 3'd0;
                    end
                end
                S_SCAN: begin
                    r_white_acc <= r_white_acc + {3'd0, popcount8(w_white_byte)};
                    r_black_acc <= r_black_acc + {3'd0, popcount8(w_black_byte)};
                    r_white_ctr <= r_white_ctr + {1'b0, w_white_center_add};
                    r_black_ctr <= r_black_ctr + {1'b0, w_black_center_add};
                    r_rank      <= r_rank + 3'd1;
                end
                S_FINISH: begin
                    r_score       <= w_score_sat;
                    r_white_count <= r_white_acc;
                    r_black_count <= r_black_acc;
                    r_eval_valid  <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign eval_valid  = r_eval_valid;
    assign score       = r_score;
    assign white_count = r_white_count;
    assign black_count = r_black_count;
    assign overrun     = r_overrun;

endmodule
`default_nettype wire

// File: tb/tb_attack_eval.sv
`default_nettype none
// ============================================================================
// Module   : tb_attack_eval
// Purpose  : Scoreboard bench for attack_eval (default build plus a narrow,
//            penalty-free build for saturation).
// Revision : 1.0 - initial release
// ============================================================================
module tb_attack_eval;

    typedef struct {
        logic signed [31:0] score;
        logic [6:0]         wc;
        logic [6:0]         bc;
        int                 cyc;
    } exp_t;

    logic              clk;
    logic              reset;
    logic [63:0]       white_is_attacking;
    logic [63:0]       black_is_attacking;
    logic              white_in_check;
    logic              black_in_check;
    logic              is_attacking_done;

    logic              eval_valid;
    logic signed [15:0] score;
    logic [6:0]        white_count;
    logic [6:0]        black_count;
    logic              busy;
    logic              overrun;

    logic              s2_eval_valid;
    logic signed [5:0] s2_score;
    logic [6:0]        s2_white_count;
    logic [6:0]        s2_black_count;
    logic              s2_busy;
    logic              s2_overrun;

    int   checks = 0;
    int   errors = 0;
    int   cyc    = 0;
    exp_t sb[$];

    attack_eval dut (
        .clk(clk), .reset(reset),
        .white_is_attacking(white_is_attacking), .black_is_attacking(black_is_attacking),
        .white_in_check(white_in_check), .black_in_check(black_in_check),
        .is_attacking_done(is_attacking_done),
        .eval_valid(eval_valid), .score(score),
        .white_count(white_count), .black_count(black_count),
        .busy(busy), .overrun(overrun)
    );

    attack_eval #(.SCORE_WIDTH(6), .CENTER_WEIGHT(1), .CHECK_PENALTY(0)) dut_sat (
        .clk(clk), .reset(reset),
        .white_is_attacking(white_is_attacking), .black_is_attacking(black_is_attacking),
        .white_in_check(white_in_check), .black_in_check(black_in_check),
        .is_attacking_done(is_attacking_done),
        .eval_valid(s2_eval_valid), .score(s2_score),
        .white_count(s2_white_count), .black_count(s2_black_count),
        .busy(s2_busy), .overrun(s2_overrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    function automatic logic signed [31:0] model_score(input logic [63:0] w, input logic [63:0] b,
                                                       input logic wchk, input logic bchk,
                                                       input int cw, input int cp, input int sw);
        longint wt, bt, s, mx, mn;
        wt = $countones(w) + cw * (int'(w[27]) + int'(w[28]) + int'(w[35]) + int'(w[36]));
        bt = $countones(b) + cw * (int'(b[27]) + int'(b[28]) + int'(b[35]) + int'(b[36]));
        s  = wt - bt - (wchk ? cp : 0) + (bchk ? cp : 0);
        mx = (64'sd1 <<< (sw - 1)) - 1;
        mn = -(64'sd1 <<< (sw - 1));
        if (s > mx) s = mx;
        if (s < mn) s = mn;
        return 32'(s);
    endfunction

    // Scoreboard consumer for the default-parameter instance.
    always @(negedge clk) begin
        if (reset && eval_valid) begin
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL unexpected_eval: got eval_valid=1 score=%0d required no pulse", score);
            end else begin
                exp_t e;
                e = sb.pop_front();
                if ($signed(score) !== e.score || white_count !== e.wc ||
                    black_count !== e.bc || cyc !== e.cyc) begin
                    errors++;
                    $display("FAIL eval: got score=%0d wc=%0d bc=%0d cyc=%0d required score=%0d wc=%0d bc=%0d cyc=%0d",
                             score, white_count, black_count, cyc, e.score, e.wc, e.bc, e.cyc);
                end
            end
        end
    end

    // Caller is at a negedge; done rises now and is sampled at the next edge (E0).
    task automatic start_eval(input logic [63:0] w, input logic [63:0] b, input logic wchk, input logic bchk);
        exp_t e;
        white_is_attacking = w;
        black_is_attacking = b;
        white_in_check     = wchk;
        black_in_check     = bchk;
        is_attacking_done  = 1'b1;
        e.score = model_score(w, b, wchk, bchk, 1, 50, 16);
        e.wc    = 7'($countones(w));
        e.bc    = 7'($countones(b));
        e.cyc   = cyc + 10;
        sb.push_back(e);
        @(negedge clk);
        is_attacking_done  = 1'b0;
        white_is_attacking = {$urandom, $urandom};
        black_is_attacking = {$urandom, $urandom};
        white_in_check     = 1'($urandom);
        black_in_check     = 1'($urandom);
    endtask

    task automatic pulse_done();
        is_attacking_done = 1'b1;
        @(negedge clk);
        is_attacking_done = 1'b0;
    endtask

    task automatic wait_drain(input string name);
        for (int i = 0; i < 40 && sb.size() != 0; i++) @(negedge clk);
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL %s_timeout: got %0d pending evaluations required 0", name, sb.size());
            sb.delete();
        end
    endtask

    task automatic test_reset();
        reset = 1'b0;
        is_attacking_done = 1'b0;
        white_is_attacking = '0;
        black_is_attacking = '0;
        white_in_check = 1'b0;
        black_in_check = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        checks++;
        if ({eval_valid, score, white_count, black_count, busy, overrun} !== '0) begin
            errors++;
            $display("FAIL reset_state: got ev=%b score=%0d wc=%0d bc=%0d busy=%b ovr=%b required all 0",
                     eval_valid, score, white_count, black_count, busy, overrun);
        end
    endtask

    task automatic test_patterns();
        start_eval(64'd0, 64'd0, 1'b0, 1'b0);
        wait_drain("zero");
        start_eval({64{1'b1}}, 64'd0, 1'b0, 1'b0);
        wait_drain("white_full");
        start_eval(64'd0, 64'd1 << 28, 1'b1, 1'b0);
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("FAIL busy_scan: got %b required 1", busy);
        end
        wait_drain("black_e4");
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL busy_after: got %b required 0", busy);
        end
        for (int i = 0; i < 4; i++) begin
            start_eval({$urandom, $urandom}, {$urandom, $urandom}, 1'($urandom), 1'($urandom));
            wait_drain("random");
        end
    endtask

    task automatic wait_sat(input logic signed [5:0] exp_s, input logic [6:0] exp_wc, input logic [6:0] exp_bc);
        int n = 0;
        while (!s2_eval_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (!s2_eval_valid || s2_score !== exp_s || s2_white_count !== exp_wc || s2_black_count !== exp_bc) begin
            errors++;
            $display("FAIL saturate: got ev=%b score=%0d wc=%0d bc=%0d required ev=1 score=%0d wc=%0d bc=%0d",
                     s2_eval_valid, s2_score, s2_white_count, s2_black_count, exp_s, exp_wc, exp_bc);
        end
        wait_drain("saturate");
    endtask

    task automatic test_saturation();
        start_eval({64{1'b1}}, 64'd0, 1'b0, 1'b0);
        wait_sat(6'sd31, 7'd64, 7'd0);
        start_eval(64'd0, {64{1'b1}}, 1'b0, 1'b0);
        wait_sat(-6'sd32, 7'd0, 7'd64);
    endtask

    task automatic test_back_to_back();
        start_eval(64'h00FF_0000_1818_0000, 64'h0000_0018_0000_FF00, 1'b0, 1'b1);
        repeat (9) @(negedge clk);
        start_eval(64'hFFFF_0000_0000_0001, 64'h8000_0000_0000_FFFF, 1'b1, 1'b0);
        wait_drain("back_to_back");
        checks++;
        if (overrun !== 1'b0) begin
            errors++;
            $display("FAIL b2b_overrun: got %b required 0", overrun);
        end
    endtask

    task automatic test_finish_edge();
        start_eval(64'h0000_0018_1800_0000, 64'd0, 1'b0, 1'b0);
        repeat (8) @(negedge clk);
        pulse_done();
        wait_drain("finish_edge");
        repeat (12) @(negedge clk);
        checks++;
        if (overrun !== 1'b1) begin
            errors++;
            $display("FAIL finish_overrun: got %b required 1", overrun);
        end
    endtask

    task automatic test_reset_mid_scan();
        start_eval({64{1'b1}}, 64'h0F0F, 1'b0, 1'b0);
        repeat (3) @(negedge clk);
        reset = 1'b0;
        sb.delete();
        #1;
        checks++;
        if ({eval_valid, score, white_count, black_count, busy, overrun} !== '0) begin
            errors++;
            $display("FAIL reset_mid: got ev=%b score=%0d wc=%0d bc=%0d busy=%b ovr=%b required all 0",
                     eval_valid, score, white_count, black_count, busy, overrun);
        end
        @(negedge clk);
        reset = 1'b1;
        repeat (14) @(negedge clk);
        checks++;
        if ({score, white_count, black_count, busy} !== '0) begin
            errors++;
            $display("FAIL reset_discard: got score=%0d wc=%0d bc=%0d busy=%b required all 0",
                     score, white_count, black_count, busy);
        end
        start_eval(64'h0000_0010_0800_0000, 64'h0000_0008_0000_0000, 1'b0, 1'b0);
        wait_drain("after_reset");
    endtask

    task automatic test_overrun();
        start_eval(64'hAAAA_5555_AAAA_5555, 64'h1234_5678_9ABC_DEF0, 1'b0, 1'b0);
        @(negedge clk);
        pulse_done();
        wait_drain("overrun");
        repeat (12) @(negedge clk);
        checks++;
        if (overrun !== 1'b1) begin
            errors++;
            $display("FAIL overrun_set: got %b required 1", overrun);
        end
        start_eval(64'd0, 64'hFF, 1'b0, 1'b0);
        wait_drain("overrun_next");
        checks++;
        if (overrun !== 1'b1) begin
            errors++;
            $display("FAIL overrun_sticky: got %b required 1", overrun);
        end
    endtask

    initial begin
        test_reset();
        test_patterns();
        test_saturation();
        test_back_to_back();
        test_finish_edge();
        test_reset_mid_scan();
        test_overrun();
        repeat (3) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/attack_eval.md
# attack_eval

Downstream consumer of the board attack stage: it waits for an attack computation to complete, then captures both 64-bit attack maps and both in-check flags. It scans the maps one rank per cycle and produces a signed positional score from White's perspective, plus raw attacked-square counts for each side. It feeds the search/evaluation logic that ranks candidate boards.

## Interface
- SCORE_WIDTH, 16: width of the signed score output; legal range 6..32.
- CENTER_WEIGHT, 1: extra weight added per attacked central square (d4, e4, d5, e5 = indices 27, 28, 35, 36; index = rank*8 + file).
- CHECK_PENALTY, 50: amount subtracted from a side's total when that side is in check.

Ports:
- clk  in  1  system clock; all state changes on the rising edge.
- reset  in  1  asynchronous, active-low reset (0 = reset asserted).
- white_is_attacking  in  64  squares attacked by White.
- black_is_attacking  in  64  squares attacked by Black.
- white_in_check  in  1  White king attacked.
- black_in_check  in  1  Black king attacked.
- is_attacking_done  in  1  level from the attack stage; a 0→1 transition marks new valid maps.
- eval_valid  out  1  one-cycle pulse; score and counts are valid and held until the next pulse.
- score  out  SCORE_WIDTH  signed White-minus-Black score, saturated.
- white_count  out  7  White attacked-square popcount, 0..64.
- black_count  out  7  Black attacked-square popcount, 0..64.
- busy  out  1  high while a capture is being evaluated.
- overrun  out  1  sticky; set when a new done edge arrives while busy.

## Operation
- The block registers is_attacking_done every cycle as done_q. A start condition is is_attacking_done=1 with done_q=0.
- FSM states: IDLE, SCAN, FINISH.
- **IDLE:** on a start edge, latch both maps and both check flags, clear the accumulators, set rank=0, and go to SCAN.
- **SCAN:** each edge adds the popcount of byte [rank*8+7 : rank*8] of each latched map to that side's count. It also adds the central bits of that rank, which occur only on ranks 3 and 4. rank increments, and after rank 7 the FSM goes to FINISH. rank is a 3-bit counter, and the transition on rank==7 takes priority over wrap-around.
- **FINISH:** compute the side totals:
  - w_tot = white_count + CENTER_WEIGHT*white_center
  - b_tot = black_count + CENTER_WEIGHT*black_center
- Then compute the score:
  - score = (w_tot − b_tot) − CHECK_PENALTY*white_in_check + CHECK_PENALTY*black_in_check
- Compute the score at 32-bit signed width. Saturate it to [−2^(SCORE_WIDTH−1), 2^(SCORE_WIDTH−1)−1].
- In FINISH, register score and the counts, pulse eval_valid, and return to IDLE.
- A start edge during SCAN or FINISH is dropped, and overrun is set to 1. The capture in progress is unaffected.
- A start edge on the same edge that FINISH returns to IDLE is also dropped with overrun=1. Only a start edge observed in IDLE starts a capture.
- Input maps may change after capture without any effect on the result.
- When reset is asserted at any point, the FSM goes to IDLE immediately and the capture in progress is discarded.

## Timing
- Reset values: eval_valid=0, score=0, white_count=0, black_count=0, busy=0, overrun=0, FSM=IDLE, done_q=0.
- Edge E0 is the first rising clock edge that samples is_attacking_done=1 with done_q=0. The capture happens at E0.
- E1..E8 scan ranks 0..7. E9 performs FINISH.
- eval_valid is high for exactly one cycle, between E9 and E10. Latency is 9 cycles.
- busy is high from E0 until E9, and low from E9 onward.
- Maximum throughput is one evaluation per 10 cycles. A start edge can be accepted at E10 at the earliest.
- If is_attacking_done is held high, it does not retrigger. It must fall and rise again.
- Outputs hold their value between eval_valid pulses.

## Test plan
- **All-zero maps, no check:** raise done → eval_valid 9 cycles later, score=0, white_count=0, black_count=0.
- **White map all ones, black zero, defaults:** white_count=64, score=68 (64 + 4 centre).
- **Black map only bit 28 (e4), white_in_check=1, defaults:** black_count=1, score = −(1+1) − 50 = −52.
- **SCORE_WIDTH=6, CHECK_PENALTY=0, White all ones:** 68 saturates to score=31; with the maps swapped, −68 saturates to −32.
- **Second done edge 3 cycles after the first (done toggled 0 between):** exactly one eval_valid with the first capture's values; overrun=1 and it stays 1 until reset.
- **reset driven 0 at E4 of a scan, released, no new edge:** all outputs 0, no eval_valid. A fresh done edge then evaluates normally with 9-cycle latency.
